// File: rtl/prio_pkg.sv
// Shared FSM encoding, code constants and helpers for the pending-request
// controller and anything that talks to it.
package prio_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] CODE_NONE = 3'b000;

    // An encoder result names a real request line only in 1..NUM_REQ.
    function automatic logic code_is_valid(input logic [CODE_W-1:0] code);
        return (code != CODE_NONE) && (code <= CODE_W'(NUM_REQ));
    endfunction

    // One-hot pending-bit mask for a request index; zero for anything else.
    function automatic logic [NUM_REQ:1] code_to_mask(input logic [CODE_W-1:0] code);
        logic [NUM_REQ:1] mask;
        mask = '0;
        case (code)
            3'd1:    mask = 4'b0001;
            3'd2:    mask = 4'b0010;
            3'd3:    mask = 4'b0100;
            3'd4:    mask = 4'b1000;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/prio_req_ctrl.sv
// Sticky request collector with an offer/accept/service handshake; relies on
// an external priority encoder fed from pend_out and returned on code_in.
module prio_req_ctrl
    import prio_pkg::*;
#(
    parameter int unsigned SVC_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ:1]     req_in,
    output logic [NUM_REQ:1]     pend_out,
    input  logic [CODE_W-1:0]    code_in,
    output logic                 grant_valid,
    output logic [CODE_W-1:0]    grant_code,
    input  logic                 grant_ready,
    output logic                 busy,
    output logic                 svc_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SVC_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CODE_W-1:0]  code_d;
    logic [NUM_REQ:1]   clr_mask;
    logic [NUM_REQ:1]   pend_d;
    logic               valid_d;
    logic               busy_d;
    logic               done_d;

    // Next state, counter, grant code and the registered output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = grant_code;
        clr_mask = '0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                code_d = CODE_NONE;
                if (code_is_valid(code_in)) begin
                    code_d  = code_in;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (grant_ready) begin
                    cnt_d   = '0;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (cnt_q == LAST_CNT) begin
                    clr_mask = code_to_mask(grant_code);
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    code_d   = CODE_NONE;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                code_d  = CODE_NONE;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A new request on the clearing edge keeps its bit set.
        pend_d  = (pend_out & ~clr_mask) | req_in;
        valid_d = (state_d == OFFER);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_out    <= '0;
            grant_code  <= CODE_NONE;
            grant_valid <= 1'b0;
            busy        <= 1'b0;
            svc_done    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_out    <= pend_d;
            grant_code  <= code_d;
            grant_valid <= valid_d;
            busy        <= busy_d;
            svc_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_prio_req_ctrl.sv
// Bench for prio_req_ctrl: behavioural priority encoder in the loop and a
// scoreboard of expected service codes checked at each svc_done.
module tb_prio_req_ctrl;

    localparam int unsigned SVC = 4;

    logic       clk;
    logic       reset_n;
    logic [4:1] req_in;
    logic [4:1] pend_out;
    logic [2:0] code_in;
    logic       grant_valid;
    logic [2:0] grant_code;
    logic       grant_ready;
    logic       busy;
    logic       svc_done;

    logic [2:0] enc_y;
    logic       force_en;
    logic [2:0] force_code;

    int vectors;
    int miscompares;
    int cyc;
    int done_count;
    int acc_cyc;
    logic [2:0] acc_code;
    logic [2:0] exp_q[$];
    int         done_cyc_q[$];

    prio_req_ctrl #(.SVC_CYCLES(SVC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_in      (req_in),
        .pend_out    (pend_out),
        .code_in     (code_in),
        .grant_valid (grant_valid),
        .grant_code  (grant_code),
        .grant_ready (grant_ready),
        .busy        (busy),
        .svc_done    (svc_done)
    );

    // Downstream 4-input priority encoder, bit 4 highest.
    always_comb begin
        casez (pend_out)
            4'b1???: enc_y = 3'd4;
            4'b01??: enc_y = 3'd3;
            4'b001?: enc_y = 3'd2;
            4'b0001: enc_y = 3'd1;
            default: enc_y = 3'd0;
        endcase
    end
    assign code_in = force_en ? force_code : enc_y;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: remember each accepted grant, check it against the queue at svc_done.
    always @(negedge clk) begin
        if (reset_n) begin
            if (svc_done) begin
                done_count++;
                done_cyc_q.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL svc_done_unexpected code=%0d exp no completion", acc_code);
                end else begin
                    logic [2:0] exp_code;
                    exp_code = exp_q.pop_front();
                    if (acc_code !== exp_code) begin
                        miscompares++;
                        $display("FAIL svc_code got %0d exp %0d", acc_code, exp_code);
                    end
                    vectors++;
                    if (cyc - acc_cyc != int'(SVC)) begin
                        miscompares++;
                        $display("FAIL svc_latency got %0d exp %0d", cyc - acc_cyc, SVC);
                    end
                end
            end
            if (grant_valid && grant_ready) begin
                acc_code = grant_code;
                acc_cyc  = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout outstanding=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({pend_out, grant_valid, grant_code, busy, svc_done} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b exp %b",
                     {pend_out, grant_valid, grant_code, busy, svc_done}, 10'b0);
        end
        reset_n = 1'b1;
        tick();
        vectors++;
        if ({pend_out, grant_valid, busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_idle got %b exp %b", {pend_out, grant_valid, busy}, 6'b0);
        end
    endtask

    task automatic test_single();
        grant_ready = 1'b1;
        exp_q.push_back(3'd2);
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        vectors++;
        if (pend_out !== 4'b0010 || grant_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pend got %b/%b exp 0010/0", pend_out, grant_valid);
        end
        tick();
        vectors++;
        if (grant_valid !== 1'b1 || grant_code !== 3'd2) begin
            miscompares++;
            $display("FAIL single_offer got %b/%0d exp 1/2", grant_valid, grant_code);
        end
        tick();
        vectors++;
        if (grant_valid !== 1'b0 || busy !== 1'b1 || grant_code !== 3'd2) begin
            miscompares++;
            $display("FAIL single_accept got %b/%b/%0d exp 0/1/2", grant_valid, busy, grant_code);
        end
        drain(20);
        tick();
        vectors++;
        if (pend_out !== 4'b0000 || busy !== 1'b0 || grant_code !== 3'd0) begin
            miscompares++;
            $display("FAIL single_end got %b/%b/%0d exp 0000/0/0", pend_out, busy, grant_code);
        end
    endtask

    task automatic test_priority();
        grant_ready = 1'b1;
        done_cyc_q.delete();
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd1);
        req_in = 4'b1011;
        tick();
        req_in = 4'b0000;
        drain(60);
        tick();
        vectors++;
        if (done_cyc_q.size() != 3) begin
            miscompares++;
            $display("FAIL prio_count got %0d exp 3", done_cyc_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                vectors++;
                if (done_cyc_q[i] - done_cyc_q[i-1] != int'(SVC) + 2) begin
                    miscompares++;
                    $display("FAIL prio_spacing%0d got %0d exp %0d", i,
                             done_cyc_q[i] - done_cyc_q[i-1], SVC + 2);
                end
            end
        end
        vectors++;
        if (pend_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL prio_end got %b exp 0000", pend_out);
        end
    endtask

    task automatic test_backpressure();
        grant_ready = 1'b0;
        exp_q.push_back(3'd3);
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        tick();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (grant_valid !== 1'b1 || grant_code !== 3'd3 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold%0d got %b/%0d/%b exp 1/3/1", i, grant_valid, grant_code, busy);
            end
            tick();
        end
        grant_ready = 1'b1;
        tick();
        vectors++;
        if (grant_valid !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept got %b/%b exp 0/1", grant_valid, busy);
        end
        drain(20);
        tick();
    endtask

    task automatic test_no_preempt();
        grant_ready = 1'b1;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd1);
        req_in = 4'b0001;
        tick();
        req_in = 4'b0000;
        tick();
        tick();
        repeat (SVC - 1) tick();
        req_in = 4'b1001;
        tick();
        req_in = 4'b0000;
        vectors++;
        if (svc_done !== 1'b1 || pend_out !== 4'b1001 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL setwins got %b/%b/%b exp 1/1001/0", svc_done, pend_out, busy);
        end
        drain(60);
        tick();
        vectors++;
        if (pend_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL nopre_end got %b exp 0000", pend_out);
        end
    endtask

    task automatic test_reset_mid();
        int saved;
        grant_ready = 1'b1;
        req_in = 4'b0010;
        tick();
        req_in = 4'b0000;
        tick();
        tick();
        tick();
        saved = done_count;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({pend_out, grant_valid, grant_code, busy, svc_done} !== 10'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs got %b exp %b",
                     {pend_out, grant_valid, grant_code, busy, svc_done}, 10'b0);
        end
        tick();
        tick();
        reset_n = 1'b1;
        req_in = 4'b0100;
        exp_q.push_back(3'd3);
        tick();
        req_in = 4'b0000;
        vectors++;
        if (pend_out !== 4'b0100) begin
            miscompares++;
            $display("FAIL midreset_resume got %b exp 0100", pend_out);
        end
        drain(20);
        tick();
        vectors++;
        if (done_count != saved + 1 || pend_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_done got %0d/%b exp %0d/0000", done_count - saved, pend_out, 1);
        end
    endtask

    task automatic test_illegal_code();
        grant_ready = 1'b1;
        force_en = 1'b1;
        force_code = 3'd5;
        req_in = 4'b0001;
        tick();
        req_in = 4'b0000;
        for (int c = 5; c <= 7; c++) begin
            force_code = 3'(c);
            repeat (3) begin
                tick();
                vectors++;
                if (grant_valid !== 1'b0 || busy !== 1'b0 || grant_code !== 3'd0) begin
                    miscompares++;
                    $display("FAIL illegal_code%0d got %b/%b/%0d exp 0/0/0", c,
                             grant_valid, busy, grant_code);
                end
            end
        end
        force_en = 1'b0;
        exp_q.push_back(3'd1);
        drain(20);
        tick();
        vectors++;
        if (pend_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL illegal_end got %b exp 0000", pend_out);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        done_count  = 0;
        acc_cyc     = 0;
        acc_code    = 3'd0;
        req_in      = 4'b0000;
        grant_ready = 1'b0;
        force_en    = 1'b0;
        force_code  = 3'd0;
        reset_n     = 1'b1;
        #1;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_no_preempt();
        test_reset_mid();
        test_illegal_code();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prio_req_ctrl.md
PRIO_REQ_CTRL -- requirements
Module: prio_req_ctrl

Interface
REQ-001 Parameter SVC_CYCLES, default 4, service duration in clock cycles (legal range 1..255).
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port reset_n  input  1  asynchronous active-low reset.
REQ-004 Port req_in  input  [4:1]  synchronous request levels; bit 4 highest priority.
REQ-005 Port pend_out  output  [4:1]  registered sticky pending vector; drives the downstream 4-input priority encoder r input.
REQ-006 Port code_in  input  [2:0]  encoder result returned combinationally (0 = none, 1..4 = index of highest pending bit).
REQ-007 Port grant_valid  output  1  grant offer valid.
REQ-008 Port grant_code  output  [2:0]  index being offered or serviced; 0 when idle.
REQ-009 Port grant_ready  input  1  consumer accepts the offer when high with grant_valid.
REQ-010 Port busy  output  1  high in any state other than IDLE.
REQ-011 Port svc_done  output  1  one-cycle pulse on completion of a service.

Function
REQ-012 Pending bit k SHALL set on any clock edge where req_in[k]=1 and stay set until cleared by completion of service of index k.
REQ-013 When set and clear of the same bit occur on one edge, set SHALL win.
REQ-014 FSM states SHALL be IDLE, OFFER, SERVICE.
REQ-015 IDLE: if code_in is 1..4, latch code_in into grant_code and go to OFFER; if code_in is 0 or 5..7, stay in IDLE.
REQ-016 OFFER: grant_valid=1; on edge with grant_ready=1, go to SERVICE and load service counter with 0; otherwise hold OFFER with grant_code stable.
REQ-017 SERVICE: counter increments each cycle; on the edge where counter = SVC_CYCLES-1, clear pend bit grant_code, pulse svc_done for the following cycle, and return to IDLE.
REQ-018 No preemption: higher-priority requests arriving in OFFER or SERVICE SHALL only set pend bits and be arbitrated on return to IDLE.
REQ-019 Latency: req_in[k] high at edge n gives pend_out[k]=1 after edge n and grant_valid=1 after edge n+1 when IDLE and k highest.
REQ-020 grant_valid SHALL be 0 outside OFFER; grant_code SHALL be 0 in IDLE.
REQ-021 Back-to-back: after SERVICE exits, IDLE SHALL evaluate code_in on the next edge with no extra idle cycle.
REQ-022 Counter width SHALL be 8 bits; no wrap occurs within legal SVC_CYCLES.

Reset
REQ-023 reset_n low SHALL asynchronously force: state IDLE, pend_out 0, grant_code 0, grant_valid 0, busy 0, svc_done 0, counter 0.
REQ-024 Reset asserted mid-OFFER or mid-SERVICE SHALL discard the grant and all pending bits; no svc_done is issued.
REQ-025 Operation SHALL resume on the first rising edge after reset_n deasserts.

Structure
REQ-026 State encoding constants (IDLE, OFFER, SERVICE) and the no-request code 3'b000 SHALL live in a shared package prio_pkg.
REQ-027 The priority encoder SHALL stay external; prio_req_ctrl SHALL instantiate no sub-module; the bench connects pend_out to r and y to code_in.
REQ-028 Single always block for sequential state, separate combinational block for next-state and outputs.

Verification
REQ-029 Single request: req_in=4'b0010 for one cycle, grant_ready=1 -> grant_code=2, grant_valid for one cycle, svc_done 4 cycles after acceptance, pend_out back to 0.
REQ-030 Priority: req_in=4'b1011 for one cycle -> services in order 4, 2, 1, each separated by exactly SVC_CYCLES+2 cycles, pend_out ends 0.
REQ-031 Backpressure: req_in=4'b0100, grant_ready=0 for 10 cycles -> grant_valid and grant_code=3 held stable; svc_done 4 cycles after grant_ready rises.
REQ-032 No preemption and set-wins: during service of 1 assert req_in=4'b1001 on the clear edge -> service 1 completes, pend_out=4'b1001, then 4 served, then 1 served again.
REQ-033 Reset mid-service: reset_n low during SERVICE cycle 2 -> all outputs 0 immediately, no svc_done, fresh request after release served normally.
REQ-034 Illegal code: force code_in=3'b110 in IDLE -> state stays IDLE, grant_valid=0.
